// File: rtl/dpram_pingpong_ctrl_pkg.sv
// Shared types for the ping-pong buffer controller: per-bank state encoding and bank count.
package dpram_pingpong_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_FULL    = 2'd2
   } bank_state_e;

   localparam int NUM_BANKS = 2;

   function automatic logic bank_writable(input bank_state_e s);
      return (s == ST_EMPTY) || (s == ST_FILLING);
   endfunction

endpackage

// File: rtl/dpram_wrapper.sv
// Simple dual-port RAM: port A writes, port B reads with an N_DELAY-cycle output pipeline.
module dpram_wrapper #(
   parameter int DW      = 32,
   parameter int AW      = 8,
   parameter int DEPTH   = 256,
   parameter int N_DELAY = 1
) (
   input  logic          clk,
   input  logic          ena,
   input  logic          wea,
   input  logic [AW-1:0] addra,
   input  logic [DW-1:0] dina,
   input  logic          enb,
   input  logic [AW-1:0] addrb,
   output logic [DW-1:0] doutb
);

   logic [DW-1:0] mem  [DEPTH];
   logic [DW-1:0] pipe [N_DELAY];

   // NOTE: storage and data pipeline carry no reset so they map onto block RAM; validity is tracked by the controller.
   always_ff @(posedge clk) begin
      if (ena && wea) mem[addra] <= dina;
      if (enb) pipe[0] <= mem[addrb];
      for (int i = 1; i < N_DELAY; i++) pipe[i] <= pipe[i-1];
   end

   assign doutb = pipe[N_DELAY-1];

endmodule

// File: rtl/dpram_pingpong_ctrl.sv
// Ping-pong controller: producer fills one bank while the consumer randomly reads the other FULL bank.
module dpram_pingpong_ctrl
   import dpram_pingpong_ctrl_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 8,
   parameter int DEPTH   = 256,
   parameter int N_DELAY = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid,
   output logic          wr_ready,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_last,
   output logic          rd_bank_vld,
   output logic [AW:0]   rd_len,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          rd_data_vld,
   input  logic          rd_done,
   output logic          err_ovf
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   bank_state_e        state_q [NUM_BANKS];
   bank_state_e        state_n [NUM_BANKS];
   logic [AW:0]        len_q   [NUM_BANKS];
   logic [AW:0]        len_n   [NUM_BANKS];
   logic [DW-1:0]      bank_dout [NUM_BANKS];
   logic               wr_bank_q, wr_bank_n, rd_bank_q, rd_bank_n;
   logic [AW-1:0]      wptr_q, wptr_n;
   logic               wr_ready_q, rd_bank_vld_q, err_ovf_q;
   logic [N_DELAY-1:0] vld_pipe, sel_pipe;
   logic               wr_accept, at_last, wr_close, rd_accept, rd_release;

   assign wr_accept  = wr_valid & wr_ready_q;
   assign at_last    = (wptr_q == LAST_ADDR);
   assign wr_close   = wr_accept & (wr_last | at_last);
   assign rd_accept  = rd_en & rd_bank_vld_q;
   assign rd_release = rd_done & rd_bank_vld_q;

   // NOTE: every variable gets its default first so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_bank_n = wr_bank_q;
      rd_bank_n = rd_bank_q;
      wptr_n    = wptr_q;
      for (int i = 0; i < NUM_BANKS; i++) begin
         state_n[i] = state_q[i];
         len_n[i]   = len_q[i];
      end
      if (wr_accept) begin
         state_n[wr_bank_q] = ST_FILLING;
         wptr_n             = wptr_q + AW'(1);
         if (wr_close) begin
            state_n[wr_bank_q] = ST_FULL;
            len_n[wr_bank_q]   = {1'b0, wptr_q} + (AW+1)'(1);
            wptr_n             = '0;
            wr_bank_n          = ~wr_bank_q;
         end
      end
      // Release targets the presented bank, which is never the one being closed this cycle.
      if (rd_release) begin
         state_n[rd_bank_q] = ST_EMPTY;
         len_n[rd_bank_q]   = '0;
         rd_bank_n          = ~rd_bank_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            state_q[i] <= ST_EMPTY;
            len_q[i]   <= '0;
         end
         wr_bank_q     <= 1'b0;
         rd_bank_q     <= 1'b0;
         wptr_q        <= '0;
         wr_ready_q    <= 1'b0;
         rd_bank_vld_q <= 1'b0;
         err_ovf_q     <= 1'b0;
         vld_pipe      <= '0;
         sel_pipe      <= '0;
      end else begin
         for (int i = 0; i < NUM_BANKS; i++) begin
            state_q[i] <= state_n[i];
            len_q[i]   <= len_n[i];
         end
         wr_bank_q     <= wr_bank_n;
         rd_bank_q     <= rd_bank_n;
         wptr_q        <= wptr_n;
         wr_ready_q    <= bank_writable(state_n[wr_bank_n]);
         rd_bank_vld_q <= (state_n[rd_bank_n] == ST_FULL);
         if (wr_accept && at_last && !wr_last) err_ovf_q <= 1'b1;
         vld_pipe[0] <= rd_accept;
         sel_pipe[0] <= rd_bank_q;
         for (int i = 1; i < N_DELAY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            sel_pipe[i] <= sel_pipe[i-1];
         end
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic ena_b, enb_b;
      assign ena_b = wr_accept && (wr_bank_q == 1'(b));
      assign enb_b = rd_accept && (rd_bank_q == 1'(b));

      dpram_wrapper #(
         .DW(DW), .AW(AW), .DEPTH(DEPTH), .N_DELAY(N_DELAY)
      ) u_ram (
         .clk   (clk),
         .ena   (ena_b),
         .wea   (1'b1),
         .addra (wptr_q),
         .dina  (wr_data),
         .enb   (enb_b),
         .addrb (rd_addr),
         .doutb (bank_dout[b])
      );
   end

   assign wr_ready    = wr_ready_q;
   assign rd_bank_vld = rd_bank_vld_q;
   assign rd_len      = len_q[rd_bank_q];
   assign rd_data_vld = vld_pipe[N_DELAY-1];
   // Data is forced to zero outside valid beats so reset clears every output at once.
   assign rd_data     = rd_data_vld ? bank_dout[sel_pipe[N_DELAY-1]] : '0;
   assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_dpram_pingpong_ctrl.sv
// Directed bench for dpram_pingpong_ctrl: one instance with N_DELAY=1, one with N_DELAY=3.
module tb_dpram_pingpong_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   int          tests_run = 0;
   int          tests_failed = 0;

   logic        wr_valid, wr_ready, wr_last, rd_bank_vld, rd_en, rd_data_vld, rd_done, err_ovf;
   logic [31:0] wr_data, rd_data;
   logic [8:0]  rd_len;
   logic [7:0]  rd_addr;

   logic        d3_wr_valid, d3_wr_ready, d3_wr_last, d3_rd_bank_vld, d3_rd_en, d3_rd_data_vld, d3_rd_done, d3_err_ovf;
   logic [31:0] d3_wr_data, d3_rd_data;
   logic [8:0]  d3_rd_len;
   logic [7:0]  d3_rd_addr;

   always #5 clk = ~clk;

   dpram_pingpong_ctrl #(.DW(32), .AW(8), .DEPTH(256), .N_DELAY(1)) u_dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .wr_last(wr_last), .rd_bank_vld(rd_bank_vld), .rd_len(rd_len), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_data_vld(rd_data_vld), .rd_done(rd_done),
      .err_ovf(err_ovf)
   );

   dpram_pingpong_ctrl #(.DW(32), .AW(8), .DEPTH(256), .N_DELAY(3)) u_dut3 (
      .clk(clk), .rst(rst), .wr_valid(d3_wr_valid), .wr_ready(d3_wr_ready), .wr_data(d3_wr_data),
      .wr_last(d3_wr_last), .rd_bank_vld(d3_rd_bank_vld), .rd_len(d3_rd_len), .rd_en(d3_rd_en),
      .rd_addr(d3_rd_addr), .rd_data(d3_rd_data), .rd_data_vld(d3_rd_data_vld), .rd_done(d3_rd_done),
      .err_ovf(d3_err_ovf)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      wr_valid = 0; wr_data = '0; wr_last = 0; rd_en = 0; rd_addr = '0; rd_done = 0;
      d3_wr_valid = 0; d3_wr_data = '0; d3_wr_last = 0; d3_rd_en = 0; d3_rd_addr = '0; d3_rd_done = 0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic put_word(input logic [31:0] d, input logic last);
      wr_valid = 1; wr_data = d; wr_last = last;
      step();
      wr_valid = 0; wr_last = 0;
   endtask

   task automatic put_word3(input logic [31:0] d, input logic last);
      d3_wr_valid = 1; d3_wr_data = d; d3_wr_last = last;
      step();
      d3_wr_valid = 0; d3_wr_last = 0;
   endtask

   task automatic test_reset();
      step();
      tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
      tests_run++; if (rd_bank_vld !== 1'b0) begin tests_failed++; $display("FAIL rst_rd_bank_vld: got %b want 0", rd_bank_vld); end
      tests_run++; if (rd_data_vld !== 1'b0) begin tests_failed++; $display("FAIL rst_rd_data_vld: got %b want 0", rd_data_vld); end
      tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
      tests_run++; if (rd_len !== 9'd0) begin tests_failed++; $display("FAIL rst_rd_len: got %0d want 0", rd_len); end
      tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL rst_err_ovf: got %b want 0", err_ovf); end
      rst = 1'b0;
      #1;
      tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_release_ready_early: got %b want 0", wr_ready); end
      step();
      tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %b want 1", wr_ready); end
      tests_run++; if (d3_wr_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready_d3: got %b want 1", d3_wr_ready); end
   endtask

   task automatic test_fill_read();
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         put_word(32'h100 + 32'(i), i == 9);
         if (i == 8) begin
            tests_run++; if (rd_bank_vld !== 1'b0) begin tests_failed++; $display("FAIL t1_vld_early: got %b want 0", rd_bank_vld); end
         end
      end
      tests_run++; if (rd_bank_vld !== 1'b1) begin tests_failed++; $display("FAIL t1_bank_vld: got %b want 1", rd_bank_vld); end
      tests_run++; if (rd_len !== 9'd10) begin tests_failed++; $display("FAIL t1_rd_len: got %0d want 10", rd_len); end
      tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL t1_wr_ready: got %b want 1", wr_ready); end
      rd_en = 1; rd_addr = 8'd3;
      step();
      rd_en = 0;
      tests_run++; if (rd_data_vld !== 1'b1) begin tests_failed++; $display("FAIL t1_data_vld: got %b want 1", rd_data_vld); end
      tests_run++; if (rd_data !== 32'h103) begin tests_failed++; $display("FAIL t1_rd_data: got %h want 103", rd_data); end
      step();
      tests_run++; if (rd_data_vld !== 1'b0) begin tests_failed++; $display("FAIL t1_data_vld_drop: got %b want 0", rd_data_vld); end
      rd_done = 1;
      step();
      rd_done = 0;
      tests_run++; if (rd_bank_vld !== 1'b0) begin tests_failed++; $display("FAIL t1_release_vld: got %b want 0", rd_bank_vld); end
      tests_run++; if (rd_len !== 9'd0) begin tests_failed++; $display("FAIL t1_release_len: got %0d want 0", rd_len); end
      rd_en = 1; rd_addr = 8'd0;
      step();
      rd_en = 0;
      tests_run++; if (rd_data_vld !== 1'b0) begin tests_failed++; $display("FAIL t1_ignored_rd_en: got %b want 0", rd_data_vld); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      for (int i = 0; i < 4; i++) put_word(32'h200 + 32'(i), i == 3);
      for (int i = 0; i < 4; i++) put_word(32'h210 + 32'(i), i == 3);
      tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL t2_both_full_ready: got %b want 0", wr_ready); end
      wr_valid = 1; wr_data = 32'h220; wr_last = 0;
      step();
      tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL t2_stall_ready: got %b want 0", wr_ready); end
      tests_run++; if (rd_len !== 9'd4) begin tests_failed++; $display("FAIL t2_bank0_len: got %0d want 4", rd_len); end
      wr_valid = 0; rd_done = 1;
      step();
      rd_done = 0;
      tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL t2_ready_after_done: got %b want 1", wr_ready); end
      tests_run++; if (rd_bank_vld !== 1'b1) begin tests_failed++; $display("FAIL t2_bank1_vld: got %b want 1", rd_bank_vld); end
      tests_run++; if (rd_len !== 9'd4) begin tests_failed++; $display("FAIL t2_bank1_len: got %0d want 4", rd_len); end
      rd_en = 1; rd_addr = 8'd0;
      step();
      tests_run++; if (rd_data !== 32'h210 || rd_data_vld !== 1'b1) begin tests_failed++; $display("FAIL t2_bank1_word0: got %h/%b want 210/1", rd_data, rd_data_vld); end
      rd_addr = 8'd3;
      step();
      rd_en = 0;
      tests_run++; if (rd_data !== 32'h213 || rd_data_vld !== 1'b1) begin tests_failed++; $display("FAIL t2_bank1_word3: got %h/%b want 213/1", rd_data, rd_data_vld); end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         put_word(32'h3000 + 32'(i), 1'b0);
         if (i == 254) begin
            tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL t3_ovf_early: got %b want 0", err_ovf); end
         end
      end
      tests_run++; if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL t3_err_ovf: got %b want 1", err_ovf); end
      tests_run++; if (rd_bank_vld !== 1'b1) begin tests_failed++; $display("FAIL t3_bank_vld: got %b want 1", rd_bank_vld); end
      tests_run++; if (rd_len !== 9'd256) begin tests_failed++; $display("FAIL t3_rd_len: got %0d want 256", rd_len); end
      tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL t3_wr_ready: got %b want 1", wr_ready); end
      rd_en = 1; rd_addr = 8'd255;
      step();
      rd_en = 0;
      tests_run++; if (rd_data !== 32'h30FF) begin tests_failed++; $display("FAIL t3_last_word: got %h want 30ff", rd_data); end
      put_word(32'hDEAD0101, 1'b1);
      rd_done = 1;
      step();
      rd_done = 0;
      tests_run++; if (rd_bank_vld !== 1'b1 || rd_len !== 9'd1) begin tests_failed++; $display("FAIL t3_bank1_present: got vld %b len %0d want 1/1", rd_bank_vld, rd_len); end
      tests_run++; if (err_ovf !== 1'b1) begin tests_failed++; $display("FAIL t3_ovf_sticky: got %b want 1", err_ovf); end
      rd_en = 1; rd_addr = 8'd0;
      step();
      rd_en = 0;
      tests_run++; if (rd_data !== 32'hDEAD0101) begin tests_failed++; $display("FAIL t3_word257: got %h want dead0101", rd_data); end
      apply_reset();
      tests_run++; if (err_ovf !== 1'b0) begin tests_failed++; $display("FAIL t3_ovf_cleared: got %b want 0", err_ovf); end
   endtask

   task automatic test_read_latency3();
      logic [31:0] exp_data [3];
      exp_data[0] = 32'h400; exp_data[1] = 32'h401; exp_data[2] = 32'h402;
      apply_reset();
      for (int i = 0; i < 3; i++) put_word3(exp_data[i], i == 2);
      tests_run++; if (d3_rd_bank_vld !== 1'b1 || d3_rd_len !== 9'd3) begin tests_failed++; $display("FAIL t4_present: got vld %b len %0d want 1/3", d3_rd_bank_vld, d3_rd_len); end
      for (int i = 0; i < 3; i++) begin
         d3_rd_en = 1; d3_rd_addr = 8'(i);
         step();
         if (i < 2) begin
            tests_run++; if (d3_rd_data_vld !== 1'b0) begin tests_failed++; $display("FAIL t4_vld_early%0d: got %b want 0", i, d3_rd_data_vld); end
         end
      end
      d3_rd_en = 0;
      tests_run++; if (d3_rd_data_vld !== 1'b1 || d3_rd_data !== exp_data[0]) begin tests_failed++; $display("FAIL t4_beat0: got %h/%b want %h/1", d3_rd_data, d3_rd_data_vld, exp_data[0]); end
      d3_rd_done = 1;
      step();
      d3_rd_done = 0;
      tests_run++; if (d3_rd_data_vld !== 1'b1 || d3_rd_data !== exp_data[1]) begin tests_failed++; $display("FAIL t4_beat1: got %h/%b want %h/1", d3_rd_data, d3_rd_data_vld, exp_data[1]); end
      tests_run++; if (d3_rd_bank_vld !== 1'b0) begin tests_failed++; $display("FAIL t4_released: got %b want 0", d3_rd_bank_vld); end
      step();
      tests_run++; if (d3_rd_data_vld !== 1'b1 || d3_rd_data !== exp_data[2]) begin tests_failed++; $display("FAIL t4_beat2: got %h/%b want %h/1", d3_rd_data, d3_rd_data_vld, exp_data[2]); end
      step();
      tests_run++; if (d3_rd_data_vld !== 1'b0) begin tests_failed++; $display("FAIL t4_vld_end: got %b want 0", d3_rd_data_vld); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      put_word(32'h500, 1'b0);
      put_word(32'h501, 1'b1);
      put_word(32'h510, 1'b0);
      wr_valid = 1; wr_data = 32'h511; wr_last = 1; rd_done = 1;
      step();
      rd_done = 0;
      tests_run++; if (rd_bank_vld !== 1'b1 || rd_len !== 9'd2) begin tests_failed++; $display("FAIL t5_bank1_present: got vld %b len %0d want 1/2", rd_bank_vld, rd_len); end
      tests_run++; if (wr_ready !== 1'b1) begin tests_failed++; $display("FAIL t5_no_stall: got %b want 1", wr_ready); end
      wr_data = 32'h520; wr_last = 0;
      step();
      wr_data = 32'h521; wr_last = 1;
      step();
      wr_valid = 0; wr_last = 0;
      tests_run++; if (wr_ready !== 1'b0) begin tests_failed++; $display("FAIL t5_both_full: got %b want 0", wr_ready); end
      rd_en = 1; rd_addr = 8'd1;
      step();
      rd_en = 0;
      tests_run++; if (rd_data !== 32'h511) begin tests_failed++; $display("FAIL t5_bank1_word1: got %h want 511", rd_data); end
      rd_done = 1;
      step();
      rd_done = 0;
      tests_run++; if (rd_len !== 9'd2) begin tests_failed++; $display("FAIL t5_bank0_len: got %0d want 2", rd_len); end
      rd_en = 1; rd_addr = 8'd0;
      step();
      rd_en = 0;
      tests_run++; if (rd_data !== 32'h520) begin tests_failed++; $display("FAIL t5_bank0_word0: got %h want 520", rd_data); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      put_word(32'h600, 1'b0);
      put_word(32'h601, 1'b1);
      wr_valid = 1; wr_data = 32'h610; wr_last = 0;
      rd_en = 1; rd_addr = 8'd0;
      step();
      tests_run++; if (rd_data_vld !== 1'b1 || rd_data !== 32'h600) begin tests_failed++; $display("FAIL t6_pre_read: got %h/%b want 600/1", rd_data, rd_data_vld); end
      wr_data = 32'h611; rd_addr = 8'd1;
      rst = 1'b1;
      #1;
      tests_run++; if (wr_ready !== 1'b0 || rd_bank_vld !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_ctrl: got ready %b vld %b want 0/0", wr_ready, rd_bank_vld); end
      tests_run++; if (rd_data_vld !== 1'b0 || rd_data !== 32'h0) begin tests_failed++; $display("FAIL t6_rst_data: got %h/%b want 0/0", rd_data, rd_data_vld); end
      tests_run++; if (rd_len !== 9'd0 || err_ovf !== 1'b0) begin tests_failed++; $display("FAIL t6_rst_len: got len %0d ovf %b want 0/0", rd_len, err_ovf); end
      step();
      tests_run++; if (rd_data_vld !== 1'b0) begin tests_failed++; $display("FAIL t6_rd_en_in_rst: got %b want 0", rd_data_vld); end
      rst = 1'b0; wr_valid = 0; rd_en = 0;
      step();
      tests_run++; if (wr_ready !== 1'b1 || rd_bank_vld !== 1'b0) begin tests_failed++; $display("FAIL t6_after_rst: got ready %b vld %b want 1/0", wr_ready, rd_bank_vld); end
      put_word(32'h6A0, 1'b1);
      tests_run++; if (rd_bank_vld !== 1'b1 || rd_len !== 9'd1) begin tests_failed++; $display("FAIL t6_refill: got vld %b len %0d want 1/1", rd_bank_vld, rd_len); end
      rd_en = 1; rd_addr = 8'd0;
      step();
      rd_en = 0;
      tests_run++; if (rd_data !== 32'h6A0) begin tests_failed++; $display("FAIL t6_refill_word0: got %h want 6a0", rd_data); end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_fill_read();
      test_backpressure();
      test_overflow();
      test_read_latency3();
      test_simultaneous();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
